// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse letter sequencer:
//   - state_t    : sequencer state encoding
//   - UNIT_*     : unit-counter reload values (in Morse units)
//   - LETTER_MAX : highest valid letter code (Z)
//   - pattern_t  : letter pattern record, 3-bit length + 4-bit dash mask
//                  (mask bit i: 1 = dash, 0 = dot; element 0 is sent first)
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_ON   = 3'd3,
        ST_GAP  = 3'd4,
        ST_CGAP = 3'd5,
        ST_FIN  = 3'd6
    } state_t;

    localparam logic [1:0] UNIT_DOT  = 2'd1;
    localparam logic [1:0] UNIT_DASH = 2'd3;
    localparam logic [1:0] UNIT_CGAP = 2'd3;

    localparam logic [4:0] LETTER_MAX = 5'd25;

    typedef struct packed {
        logic [2:0] len;
        logic [3:0] mask;
    } pattern_t;

    // Units an element stays on: 1 for a dot, 3 for a dash.
    function automatic logic [1:0] element_units(input logic is_dash);
        return is_dash ? UNIT_DASH : UNIT_DOT;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Combinational letter -> Morse pattern table for A..Z.
// Ports:
//   letter  in  5  letter code, 0 = A ... 25 = Z, 26..31 invalid
//   pattern out    {len, mask}; mask bit i = element i (1 = dash)
//   valid   out 1  letter is within A..Z
// -----------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
(
    input  logic [4:0] letter,
    output pattern_t   pattern,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default before the case so that codes
        // missing from the table cannot leave a path that infers a latch.
        pattern = '0;
        valid   = (letter <= LETTER_MAX);
        case (letter)
            5'd0:  pattern = '{len: 3'd2, mask: 4'b0010}; // A .-
            5'd1:  pattern = '{len: 3'd4, mask: 4'b0001}; // B -...
            5'd2:  pattern = '{len: 3'd4, mask: 4'b0101}; // C -.-.
            5'd3:  pattern = '{len: 3'd3, mask: 4'b0001}; // D -..
            5'd4:  pattern = '{len: 3'd1, mask: 4'b0000}; // E .
            5'd5:  pattern = '{len: 3'd4, mask: 4'b0100}; // F ..-.
            5'd6:  pattern = '{len: 3'd3, mask: 4'b0011}; // G --.
            5'd7:  pattern = '{len: 3'd4, mask: 4'b0000}; // H ....
            5'd8:  pattern = '{len: 3'd2, mask: 4'b0000}; // I ..
            5'd9:  pattern = '{len: 3'd4, mask: 4'b1110}; // J .---
            5'd10: pattern = '{len: 3'd3, mask: 4'b0101}; // K -.-
            5'd11: pattern = '{len: 3'd4, mask: 4'b0010}; // L .-..
            5'd12: pattern = '{len: 3'd2, mask: 4'b0011}; // M --
            5'd13: pattern = '{len: 3'd2, mask: 4'b0001}; // N -.
            5'd14: pattern = '{len: 3'd3, mask: 4'b0111}; // O ---
            5'd15: pattern = '{len: 3'd4, mask: 4'b0110}; // P .--.
            5'd16: pattern = '{len: 3'd4, mask: 4'b1011}; // Q --.-
            5'd17: pattern = '{len: 3'd3, mask: 4'b0010}; // R .-.
            5'd18: pattern = '{len: 3'd3, mask: 4'b0000}; // S ...
            5'd19: pattern = '{len: 3'd1, mask: 4'b0001}; // T -
            5'd20: pattern = '{len: 3'd3, mask: 4'b0100}; // U ..-
            5'd21: pattern = '{len: 3'd4, mask: 4'b1000}; // V ...-
            5'd22: pattern = '{len: 3'd3, mask: 4'b0110}; // W .--
            5'd23: pattern = '{len: 3'd4, mask: 4'b1001}; // X -..-
            5'd24: pattern = '{len: 3'd4, mask: 4'b1101}; // Y -.--
            5'd25: pattern = '{len: 3'd4, mask: 4'b0011}; // Z --..
            default: pattern = '0;
        endcase
    end

endmodule

// File: rtl/morse_sequencer.sv
// -----------------------------------------------------------------------------
// morse_sequencer
// Sends one Morse letter on morse_out, timing each unit with ticks from an
// external unit-tick rate divider that it clears and enables.
// Ports:
//   clock_in     in   1          system clock, rising edge
//   clear        in   1          synchronous active-high reset
//   start        in   1          send request, sampled only in IDLE
//   letter       in   5          0 = A ... 25 = Z; 26..31 raise err
//   tick_in      in   1          one-cycle unit tick from the divider
//   div_clear_b  out  1          active-low synchronous clear to the divider
//   div_enable   out  1          divider count enable
//   div_load     out  DIV_WIDTH  divider reload value (UNIT_CYCLES)
//   morse_out    out  1          Morse line, 1 = tone on
//   busy         out  1          sequencer not idle
//   done         out  1          one-cycle pulse at end of character
//   err          out  1          one-cycle pulse for start with invalid letter
// -----------------------------------------------------------------------------
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int DIV_WIDTH   = 26,
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic                 clock_in,
    input  logic                 clear,
    input  logic                 start,
    input  logic [4:0]           letter,
    input  logic                 tick_in,
    output logic                 div_clear_b,
    output logic                 div_enable,
    output logic [DIV_WIDTH-1:0] div_load,
    output logic                 morse_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_t     state;
    pattern_t   pattern;
    logic [1:0] elem_idx;
    logic [1:0] unit_cnt;

    pattern_t   lut_pattern;
    logic       lut_valid;

    logic [1:0] last_idx;
    logic [1:0] next_idx;

    assign div_load = DIV_WIDTH'(UNIT_CYCLES);

    // Length 1..4 maps onto index 0..3 through its two low bits (4 -> 0 - 1 = 3).
    assign last_idx = pattern.len[1:0] - 2'd1;
    assign next_idx = elem_idx + 2'd1;

    morse_lut u_lut (
        .letter  (letter),
        .pattern (lut_pattern),
        .valid   (lut_valid)
    );

    // Outputs are registered decodes of the current state, so each one
    // follows its state by one cycle; this is what places the first tone
    // three edges after the start is sampled.
    always_ff @(posedge clock_in) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here samples the pre-edge values of the others.
        if (clear) begin
            state       <= ST_IDLE;
            elem_idx    <= 2'd0;
            unit_cnt    <= 2'd0;
            morse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            div_enable  <= 1'b0;
            div_clear_b <= 1'b1;
        end else begin
            morse_out   <= (state == ST_ON);
            busy        <= (state != ST_IDLE);
            done        <= (state == ST_FIN);
            div_enable  <= state inside {ST_ARM, ST_ON, ST_GAP, ST_CGAP};
            div_clear_b <= (state != ST_LOAD);
            err         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (lut_valid) begin
                            // NOTE: the pattern register is left out of reset;
                            // it is always written here before anything reads it.
                            pattern  <= lut_pattern;
                            elem_idx <= 2'd0;
                            state    <= ST_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                ST_LOAD: state <= ST_ARM;

                // The divider was just cleared, so no tick can be pending here.
                ST_ARM: begin
                    unit_cnt <= element_units(pattern.mask[elem_idx]);
                    state    <= ST_ON;
                end

                ST_ON, ST_GAP, ST_CGAP: begin
                    if (tick_in) begin
                        if (unit_cnt == 2'd1) begin
                            // Reloaded on the final unit, so the counter never wraps.
                            case (state)
                                ST_ON: begin
                                    if (elem_idx == last_idx) begin
                                        unit_cnt <= UNIT_CGAP;
                                        state    <= ST_CGAP;
                                    end else begin
                                        unit_cnt <= UNIT_DOT;
                                        state    <= ST_GAP;
                                    end
                                end
                                ST_GAP: begin
                                    elem_idx <= next_idx;
                                    unit_cnt <= element_units(pattern.mask[next_idx]);
                                    state    <= ST_ON;
                                end
                                default: state <= ST_FIN;
                            endcase
                        end else begin
                            unit_cnt <= unit_cnt - 2'd1;
                        end
                    end
                end

                ST_FIN: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_morse_sequencer
// Bench for morse_sequencer with UNIT_CYCLES = 4 and a behavioural model of
// the unit-tick rate divider. Each scenario pushes the expected per-cycle
// output vector into a queue; a negedge monitor pops and compares.
// Vector layout: {morse_out, busy, done, err, div_enable, div_clear_b}.
// -----------------------------------------------------------------------------
module tb_morse_sequencer;

    localparam int DW = 26;
    localparam int UC = 4;

    typedef struct packed {
        logic morse;
        logic busy;
        logic done;
        logic err;
        logic en;
        logic clr_b;
    } exp_t;

    localparam exp_t E_IDLE = 6'b000001;
    localparam exp_t E_LOAD = 6'b010000;
    localparam exp_t E_ARM  = 6'b010011;
    localparam exp_t E_ON   = 6'b110011;
    localparam exp_t E_OFF  = 6'b010011;
    localparam exp_t E_DONE = 6'b011001;
    localparam exp_t E_ERR  = 6'b000101;

    logic          clock_in = 1'b0;
    logic          clear;
    logic          start;
    logic [4:0]    letter;
    logic          tick_in;
    logic          div_clear_b;
    logic          div_enable;
    logic [DW-1:0] div_load;
    logic          morse_out;
    logic          busy;
    logic          done;
    logic          err;

    int     checks = 0;
    int     errors = 0;
    exp_t   exp_q[$];
    exp_t   mon_exp;
    exp_t   obs;
    int     mon_idx = 0;
    string  cur_test = "none";

    string tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--.."};

    morse_sequencer #(
        .DIV_WIDTH   (DW),
        .UNIT_CYCLES (UC)
    ) dut (
        .clock_in    (clock_in),
        .clear       (clear),
        .start       (start),
        .letter      (letter),
        .tick_in     (tick_in),
        .div_clear_b (div_clear_b),
        .div_enable  (div_enable),
        .div_load    (div_load),
        .morse_out   (morse_out),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock_in = ~clock_in;

    // Rate divider model: counts 0..load-1 while enabled, ticks on the last count.
    logic [DW-1:0] div_cnt;
    always @(posedge clock_in) begin
        if (clear || !div_clear_b)
            div_cnt <= '0;
        else if (div_enable)
            div_cnt <= (div_cnt == div_load - 1) ? '0 : div_cnt + 1'b1;
    end
    assign tick_in = div_enable && (div_cnt == div_load - 1);

    // Scoreboard monitor.
    always @(negedge clock_in) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            obs     = {morse_out, busy, done, err, div_enable, div_clear_b};
            checks++;
            if (obs !== mon_exp) begin
                errors++;
                $display("FAIL %s cycle %0d: {morse,busy,done,err,en,clr_b} got %b expected %b",
                         cur_test, mon_idx, obs, mon_exp);
            end
            mon_idx++;
        end
    end

    task automatic pulse_start(input logic [4:0] code);
        @(posedge clock_in);
        #1 start = 1'b1;
        letter = code;
        @(posedge clock_in);
        #1 start = 1'b0;
        mon_idx = 0;
    endtask

    // Expected vectors from the cycle after the sampling edge onwards.
    task automatic push_letter(input int code, input bit trailing);
        string p;
        p = tab[code];
        exp_q.push_back(E_IDLE);
        exp_q.push_back(E_LOAD);
        exp_q.push_back(E_ARM);
        for (int i = 0; i < p.len(); i++) begin
            int on_len;
            int off_len;
            on_len  = (p[i] == "-") ? 3 * UC : UC;
            off_len = (i == p.len() - 1) ? 3 * UC : UC;
            repeat (on_len)  exp_q.push_back(E_ON);
            repeat (off_len) exp_q.push_back(E_OFF);
        end
        exp_q.push_back(E_DONE);
        if (trailing) repeat (3) exp_q.push_back(E_IDLE);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clock_in);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d expected cycles left, required 0", cur_test, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        clear = 1'b1;
        start = 1'b0;
        letter = 5'd0;
        repeat (3) @(posedge clock_in);
        #1 clear = 1'b0;
        @(negedge clock_in);
        obs = {morse_out, busy, done, err, div_enable, div_clear_b};
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL reset_outputs got %b expected %b", obs, E_IDLE);
        end
        checks++;
        if (div_load !== DW'(UC)) begin
            errors++;
            $display("FAIL reset_div_load got %0d expected %0d", div_load, UC);
        end
    endtask

    task automatic test_letters();
        cur_test = "letter_A";
        pulse_start(5'd0);
        push_letter(0, 1'b1);
        wait_empty(500);
        cur_test = "letter_Y";
        pulse_start(5'd24);
        push_letter(24, 1'b1);
        wait_empty(500);
    endtask

    task automatic test_invalid();
        cur_test = "invalid_27";
        pulse_start(5'd27);
        exp_q.push_back(E_ERR);
        repeat (3) exp_q.push_back(E_IDLE);
        wait_empty(50);
    endtask

    task automatic test_ignore_busy();
        cur_test = "ignore_busy";
        pulse_start(5'd0);
        push_letter(0, 1'b1);
        // Index 14 lies inside A's dash; the start is sampled on the next edge.
        repeat (15) @(negedge clock_in);
        #1 start = 1'b1;
        letter = 5'd4;
        @(posedge clock_in);
        #1 start = 1'b0;
        wait_empty(500);
    endtask

    task automatic test_abort();
        cur_test = "abort_Q";
        pulse_start(5'd16);
        push_letter(16, 1'b0);
        // Index 22 lies inside Q's second dash.
        repeat (23) @(negedge clock_in);
        #1 clear = 1'b1;
        exp_q.delete();
        @(posedge clock_in);
        #1 clear = 1'b0;
        @(negedge clock_in);
        checks++;
        if ({morse_out, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_outputs {morse,busy} got %b expected 00", {morse_out, busy});
        end
        cur_test = "after_abort_E";
        pulse_start(5'd4);
        push_letter(4, 1'b1);
        wait_empty(500);
    endtask

    task automatic test_back_to_back();
        cur_test = "b2b_E";
        pulse_start(5'd4);
        push_letter(4, 1'b0);
        wait_empty(500);
        cur_test = "b2b_T";
        pulse_start(5'd19);
        push_letter(19, 1'b1);
        wait_empty(500);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_letters();
        test_invalid();
        test_ignore_busy();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
